// File: rtl/seg7_rx_monitor.sv
// seg7_rx_monitor: watches a 7-segment display bus that is asynchronous to clk.
// It decodes each stable pattern into a digit, checks that digits count
// upward modulo 10, and measures the clk cycles between successive digits.
//
// Ports:
//   clk           single clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   seg_in[6:0]   {g,f,e,d,c,b,a} segment pattern, active-high, asynchronous
//   digit[3:0]    last accepted legal digit 0..9
//   digit_valid   one-cycle pulse per accepted legal pattern change
//   seg_err       one-cycle pulse per accepted illegal pattern
//   seq_err       one-cycle pulse when an accepted digit is not previous+1 mod 10
//   period        cycles between the last two digit_valid pulses (saturating)
//   period_valid  period holds a real measurement
//   locked        two or more consecutive correct steps seen
//   err_count[7:0] saturating count of seg_err/seq_err pulses
//
// Build option: define SEG7_RX_ERRCNT_EN to enable the error counter; without
// it err_count is tied to zero.

module seg7_rx_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          seg_in,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                seg_err,
  output logic                seq_err,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                locked,
  output logic [7:0]          err_count
);

  typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;

  localparam logic [3:0] StableMax = 4'(STABLE_CYCLES);

  logic [6:0]          sync1_q, sync2_q;
  logic [6:0]          cand_q, last_q;
  logic [3:0]          stab_cnt_q, stab_cnt_d;
  logic                accept;
  logic [3:0]          dec_digit;
  logic                dec_legal;
  logic [3:0]          exp_digit;
  logic [1:0]          step_q, step_inc;
  state_e              state_q;
  logic [3:0]          digit_q;
  logic                digit_valid_q, seg_err_q, seq_err_q;
  logic [PERIOD_W-1:0] cyc_q, period_q;
  logic                period_valid_q;

  // Stability filter: count consecutive identical synchronized samples; the
  // count saturates at StableMax so a held pattern never re-triggers.
  always_comb begin
    stab_cnt_d = 4'd1;
    if (sync2_q == cand_q) begin
      stab_cnt_d = (stab_cnt_q >= StableMax) ? stab_cnt_q : stab_cnt_q + 4'd1;
    end
  end

  assign accept = (stab_cnt_d == StableMax) && (sync2_q != last_q);

  always_comb begin
    dec_digit = 4'd0;
    dec_legal = 1'b1;
    unique case (sync2_q)
      7'h3F: dec_digit = 4'd0;
      7'h06: dec_digit = 4'd1;
      7'h5B: dec_digit = 4'd2;
      7'h4F: dec_digit = 4'd3;
      7'h66: dec_digit = 4'd4;
      7'h6D: dec_digit = 4'd5;
      7'h7D: dec_digit = 4'd6;
      7'h07: dec_digit = 4'd7;
      7'h7F: dec_digit = 4'd8;
      7'h6F: dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  assign exp_digit = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
  assign step_inc  = (step_q == 2'd2) ? 2'd2 : step_q + 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q        <= 7'h00;
      sync2_q        <= 7'h00;
      cand_q         <= 7'h00;
      last_q         <= 7'h00;
      stab_cnt_q     <= 4'd0;
      step_q         <= 2'd0;
      state_q        <= StIdle;
      digit_q        <= 4'd0;
      digit_valid_q  <= 1'b0;
      seg_err_q      <= 1'b0;
      seq_err_q      <= 1'b0;
      cyc_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      sync1_q       <= seg_in;
      sync2_q       <= sync1_q;
      cand_q        <= sync2_q;
      stab_cnt_q    <= stab_cnt_d;
      digit_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      seq_err_q     <= 1'b0;
      if (cyc_q != '1) begin
        cyc_q <= cyc_q + PERIOD_W'(1);
      end

      if (accept) begin
        last_q <= sync2_q;
        if (!dec_legal) begin
          // Illegal pattern: no sequence check, lose the reference entirely.
          seg_err_q      <= 1'b1;
          period_valid_q <= 1'b0;
          state_q        <= StIdle;
          step_q         <= 2'd0;
        end else begin
          digit_q       <= dec_digit;
          digit_valid_q <= 1'b1;
          // The counter restarts at 1 so that k edges later it reads k.
          cyc_q         <= PERIOD_W'(1);
          if (state_q == StIdle) begin
            state_q <= StTrack;
            step_q  <= 2'd0;
          end else begin
            period_q       <= cyc_q;
            period_valid_q <= 1'b1;
            if (dec_digit == exp_digit) begin
              step_q  <= step_inc;
              state_q <= (step_inc == 2'd2) ? StLocked : StTrack;
            end else begin
              seq_err_q <= 1'b1;
              step_q    <= 2'd0;
              state_q   <= StTrack;
            end
          end
        end
      end
    end
  end

`ifdef SEG7_RX_ERRCNT_EN
  logic       err_evt;
  logic [7:0] err_count_q;

  // Mirrors the conditions that set seg_err_q / seq_err_q on this edge.
  assign err_evt = accept &&
                   (!dec_legal || ((state_q != StIdle) && (dec_digit != exp_digit)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= 8'd0;
    end else if (err_evt && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = 8'd0;
`endif

  assign digit        = digit_q;
  assign digit_valid  = digit_valid_q;
  assign seg_err      = seg_err_q;
  assign seq_err      = seq_err_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = (state_q == StLocked);

endmodule

// File: tb/tb_seg7_rx_monitor.sv
// Directed bench for seg7_rx_monitor with default parameters. Inputs change on
// the falling edge; outputs are sampled on the falling edge.

module tb_seg7_rx_monitor;

  localparam int PW = 24;

  logic          clk;
  logic          rst_n;
  logic [6:0]    seg_in;
  logic [3:0]    digit;
  logic          digit_valid;
  logic          seg_err;
  logic          seq_err;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic [7:0]    err_count;

  int errors = 0;
  int checks = 0;

  seg7_rx_monitor #(
    .STABLE_CYCLES(4),
    .PERIOD_W     (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .digit       (digit),
    .digit_valid (digit_valid),
    .seg_err     (seg_err),
    .seq_err     (seq_err),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    int         hold;
    int         dv;
    int         se;
    int         qe;
    int         digit;
    int         locked;
    int         pv;
    int         period;
    int         err;
  } vec_t;

  vec_t vecs [20];

  function automatic int exp_err(input int e);
`ifdef SEG7_RX_ERRCNT_EN
    return e;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a pattern at the current falling edge and hold it for 'hold' cycles,
  // counting output pulses; first_dv is the sample index of the first pulse.
  task automatic apply(input logic [6:0] v, input int hold, output int ndv,
                       output int nse, output int nqe, output int first_dv);
    seg_in   = v;
    ndv      = 0;
    nse      = 0;
    nqe      = 0;
    first_dv = 0;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      if (digit_valid === 1'b1) begin
        ndv++;
        if (first_dv == 0) first_dv = k;
      end
      if (seg_err === 1'b1) nse++;
      if (seq_err === 1'b1) nqe++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " digit"}, int'(digit), 0);
    check({tag, " digit_valid"}, int'(digit_valid), 0);
    check({tag, " seg_err"}, int'(seg_err), 0);
    check({tag, " seq_err"}, int'(seq_err), 0);
    check({tag, " period"}, int'(period), 0);
    check({tag, " period_valid"}, int'(period_valid), 0);
    check({tag, " locked"}, int'(locked), 0);
    check({tag, " err_count"}, int'(err_count), 0);
  endtask

  initial begin
    int ndv, nse, nqe, first;

    //            seg    hold dv se qe dig lk pv per  err
    vecs[0]  = '{7'h06, 100, 1, 0, 0, 1,  0, 1, 100, 0};
    vecs[1]  = '{7'h5B, 100, 1, 0, 0, 2,  1, 1, 100, 0};
    vecs[2]  = '{7'h4F, 50,  1, 0, 0, 3,  1, 1, 100, 0};
    vecs[3]  = '{7'h6D, 60,  1, 0, 1, 5,  0, 1, 50,  1};
    vecs[4]  = '{7'h66, 40,  1, 0, 1, 4,  0, 1, 60,  2};
    vecs[5]  = '{7'h6D, 30,  1, 0, 0, 5,  0, 1, 40,  2};
    vecs[6]  = '{7'h7D, 30,  1, 0, 0, 6,  1, 1, 30,  2};
    vecs[7]  = '{7'h07, 30,  1, 0, 0, 7,  1, 1, 30,  2};
    vecs[8]  = '{7'h7F, 30,  1, 0, 0, 8,  1, 1, 30,  2};
    vecs[9]  = '{7'h6F, 30,  1, 0, 0, 9,  1, 1, 30,  2};
    vecs[10] = '{7'h3F, 30,  1, 0, 0, 0,  1, 1, 30,  2};
    vecs[11] = '{7'h06, 30,  1, 0, 0, 1,  1, 1, 30,  2};
    vecs[12] = '{7'h7F, 3,   0, 0, 0, 1,  1, 1, 30,  2};
    vecs[13] = '{7'h06, 20,  0, 0, 0, 1,  1, 1, 30,  2};
    vecs[14] = '{7'h5B, 30,  1, 0, 0, 2,  1, 1, 53,  2};
    vecs[15] = '{7'h00, 30,  0, 1, 0, 2,  0, 0, 53,  3};
    vecs[16] = '{7'h4F, 30,  1, 0, 0, 3,  0, 0, 53,  3};
    vecs[17] = '{7'h66, 30,  1, 0, 0, 4,  0, 1, 30,  3};
    vecs[18] = '{7'h3F, 30,  1, 0, 1, 0,  0, 1, 30,  4};
    vecs[19] = '{7'h12, 30,  0, 1, 0, 0,  0, 0, 30,  5};

    rst_n  = 1'b0;
    seg_in = 7'h00;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // First digit from IDLE: pulse on the 6th edge, no period measurement yet.
    apply(7'h3F, 100, ndv, nse, nqe, first);
    check("first dv count", ndv, 1);
    check("first dv latency", first, 6);
    check("first errs", nse + nqe, 0);
    check("first digit", int'(digit), 0);
    check("first locked", int'(locked), 0);
    check("first period_valid", int'(period_valid), 0);

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].seg, vecs[i].hold, ndv, nse, nqe, first);
      check($sformatf("v%0d dv", i), ndv, vecs[i].dv);
      check($sformatf("v%0d seg_err", i), nse, vecs[i].se);
      check($sformatf("v%0d seq_err", i), nqe, vecs[i].qe);
      check($sformatf("v%0d digit", i), int'(digit), vecs[i].digit);
      check($sformatf("v%0d locked", i), int'(locked), vecs[i].locked);
      check($sformatf("v%0d period_valid", i), int'(period_valid), vecs[i].pv);
      check($sformatf("v%0d period", i), int'(period), vecs[i].period);
      check($sformatf("v%0d err_count", i), int'(err_count), exp_err(vecs[i].err));
    end

    // Reset in the middle of filtering a new pattern discards the progress.
    apply(7'h06, 3, ndv, nse, nqe, first);
    check("prefilter dv", ndv, 0);
    rst_n = 1'b0;
    apply(7'h06, 2, ndv, nse, nqe, first);
    check("in-reset dv", ndv, 0);
    check_reset_state("midreset");
    rst_n = 1'b1;
    apply(7'h06, 10, ndv, nse, nqe, first);
    check("post-reset dv count", ndv, 1);
    check("post-reset dv latency", first, 6);
    check("post-reset digit", int'(digit), 1);
    check("post-reset period_valid", int'(period_valid), 0);
    check("post-reset locked", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
